// File: rtl/mac_tx_pkg.sv
// rtl/mac_tx_pkg.sv - shared state, descriptor types and payload limits for the MAC TX frame feeder
package mac_tx_pkg;

    localparam int DEF_MIN_PAYLOAD = 46;
    localparam int DEF_MAX_PAYLOAD = 1500;
    localparam int PTR_FIELD_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND,
        RELEASE,
        COLL,
        BACKOFF
    } feeder_state_t;

    typedef struct packed {
        logic [PTR_FIELD_W-1:0] start_ptr;
        logic [15:0]            len;
    } len_entry_t;

endpackage

// File: rtl/mac_tx_len_queue.sv
// rtl/mac_tx_len_queue.sv - FIFO of committed frame descriptors {start_ptr, len}
module mac_tx_len_queue
    import mac_tx_pkg::*;
#(
    parameter int DEPTH_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  len_entry_t       i_push_entry,
    input  logic             i_pop,
    output len_entry_t       o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [DEPTH_W:0] o_count
);

    localparam logic [DEPTH_W:0] DEPTH = (DEPTH_W+1)'(2**DEPTH_W);

    len_entry_t         r_mem [2**DEPTH_W];
    logic [DEPTH_W-1:0] r_wptr;
    logic [DEPTH_W-1:0] r_rptr;
    logic [DEPTH_W:0]   r_count;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_push_entry;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + DEPTH_W'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + DEPTH_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (DEPTH_W+1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_full  = (r_count == DEPTH);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/mac_tx_frame_feeder.sv
// rtl/mac_tx_frame_feeder.sv - buffers host payload frames and feeds them to the MII/GMII transmitter
// Optional collision retry with backoff: define MAC_TX_RETRY_EN.
module mac_tx_frame_feeder
    import mac_tx_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int LEN_DEPTH_W = 2,
    parameter int MIN_PAYLOAD = DEF_MIN_PAYLOAD,
    parameter int MAX_PAYLOAD = DEF_MAX_PAYLOAD
) (
    input  logic                   tx_clk_i,
    input  logic                   reset_i,
    input  logic                   wr_en_i,
    input  logic [31:0]            wr_data_i,
    input  logic                   wr_last_i,
    input  logic [15:0]            wr_len_i,
    output logic                   wr_full_o,
    output logic                   wr_err_o,
    output logic                   tran_start_o,
    output logic [15:0]            tran_len_o,
    output logic [31:0]            tran_data_o,
    input  logic                   data_rd_i,
    input  logic                   frame_done_i,
    input  logic                   col_err_i,
    output logic [LEN_DEPTH_W:0]   frames_pend_o
);

    localparam int              PW        = ADDR_W + 1;
    localparam logic [PW-1:0]   RAM_WORDS = PW'(2**ADDR_W);

    feeder_state_t    r_state, w_state_nxt;
    logic [PW-1:0]    r_wr_ptr, r_frame_start, r_free_ptr, r_start_ptr, r_rd_ptr;
    logic [PW-1:0]    w_wr_ptr_nxt, w_free_ptr_nxt, w_used_nxt, w_rd_ptr_nxt;
    logic             r_ram_full, r_wr_err;
    logic [15:0]      r_tran_len, r_word_cnt, r_served;
    logic [1:0]       r_len_lsb;
    logic [31:0]      r_rd_q, w_tran_data;
    logic [31:0]      r_mem [2**ADDR_W];
    logic             w_wr_acc, w_commit, w_commit_err, w_push;
    logic [16:0]      w_len_words, w_frame_words;
    logic             w_latch, w_pop, w_rewind;
    logic             w_q_full, w_q_empty;
    len_entry_t       w_q_head, w_push_entry;
    logic             w_unused_head;

    // Write side: words land in RAM immediately but only become readable once committed
    assign w_wr_acc      = wr_en_i && !wr_full_o;
    assign w_commit      = w_wr_acc && wr_last_i;
    assign w_len_words   = (17'(wr_len_i) + 17'd3) >> 2;
    assign w_frame_words = 17'(r_wr_ptr - r_frame_start) + 17'd1;
    assign w_commit_err  = w_commit && ((wr_len_i == 16'd0) ||
                                        (wr_len_i > 16'(MAX_PAYLOAD)) ||
                                        (w_len_words != w_frame_words));
    assign w_push        = w_commit && !w_commit_err;

    assign w_push_entry.start_ptr = PTR_FIELD_W'(r_frame_start);
    assign w_push_entry.len       = wr_len_i;
    assign w_unused_head          = ^w_q_head.start_ptr[PTR_FIELD_W-1:PW];

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        if (w_commit_err) begin
            w_wr_ptr_nxt = r_frame_start;
        end else if (w_wr_acc) begin
            w_wr_ptr_nxt = r_wr_ptr + PW'(1);
        end
    end

    assign w_free_ptr_nxt = w_pop ? (r_start_ptr + r_word_cnt[PW-1:0]) : r_free_ptr;
    assign w_used_nxt     = w_wr_ptr_nxt - w_free_ptr_nxt;

    always_ff @(posedge tx_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wr_ptr      <= '0;
            r_frame_start <= '0;
            r_free_ptr    <= '0;
            r_ram_full    <= 1'b0;
            r_wr_err      <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_free_ptr <= w_free_ptr_nxt;
            r_ram_full <= (w_used_nxt == RAM_WORDS);
            r_wr_err   <= w_commit_err;
            if (w_push) begin
                r_frame_start <= r_wr_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge tx_clk_i) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data_i;
        end
    end

    mac_tx_len_queue #(
        .DEPTH_W (LEN_DEPTH_W)
    ) u_len_queue (
        .i_clk        (tx_clk_i),
        .i_rst_n      (reset_i),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_q_head),
        .o_full       (w_q_full),
        .o_empty      (w_q_empty),
        .o_count      (frames_pend_o)
    );

`ifdef MAC_TX_RETRY_EN
    logic [3:0] r_retry_cnt;
    logic [7:0] r_backoff;
`endif

    always_ff @(posedge tx_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_pop       = 1'b0;
        w_rewind    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_q_empty) begin
                    w_latch     = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: w_state_nxt = SEND;
            SEND: begin
                if (col_err_i) begin
                    w_state_nxt = COLL;
                end else if (frame_done_i) begin
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                w_pop       = 1'b1;
                w_state_nxt = IDLE;
            end
            COLL: begin
`ifdef MAC_TX_RETRY_EN
                if (r_retry_cnt == 4'd15) begin
                    w_pop       = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_rewind    = 1'b1;
                    w_state_nxt = BACKOFF;
                end
`else
                w_pop       = 1'b1;
                w_state_nxt = IDLE;
`endif
            end
`ifdef MAC_TX_RETRY_EN
            BACKOFF: begin
                if (r_backoff == 8'd1) begin
                    w_state_nxt = START;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef MAC_TX_RETRY_EN
    always_ff @(posedge tx_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_retry_cnt <= '0;
            r_backoff   <= '0;
        end else if (w_pop) begin
            r_retry_cnt <= '0;
        end else if (w_rewind) begin
            r_retry_cnt <= r_retry_cnt + 4'd1;
            r_backoff   <= {r_retry_cnt + 4'd1, 4'd0};
        end else if (r_state == BACKOFF) begin
            r_backoff <= r_backoff - 8'd1;
        end
    end
`endif

    // RAM is addressed with the next read pointer so r_rd_q always holds RAM[r_rd_ptr]
    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        if (w_latch) begin
            w_rd_ptr_nxt = w_q_head.start_ptr[PW-1:0];
        end else if (w_rewind) begin
            w_rd_ptr_nxt = r_start_ptr;
        end else if ((r_state == SEND) && data_rd_i) begin
            w_rd_ptr_nxt = r_rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge tx_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_rd_ptr    <= '0;
            r_rd_q      <= '0;
            r_start_ptr <= '0;
            r_tran_len  <= '0;
            r_word_cnt  <= '0;
            r_served    <= '0;
            r_len_lsb   <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_nxt;
            r_rd_q   <= r_mem[w_rd_ptr_nxt[ADDR_W-1:0]];
            if (w_latch) begin
                r_start_ptr <= w_q_head.start_ptr[PW-1:0];
                r_tran_len  <= (w_q_head.len < 16'(MIN_PAYLOAD)) ? 16'(MIN_PAYLOAD) : w_q_head.len;
                r_word_cnt  <= (w_q_head.len + 16'd3) >> 2;
                r_len_lsb   <= w_q_head.len[1:0];
                r_served    <= '0;
            end else if (w_rewind) begin
                r_served <= '0;
            end else if ((r_state == SEND) && data_rd_i && (r_served != 16'hFFFF)) begin
                r_served <= r_served + 16'd1;
            end
        end
    end

    always_comb begin
        w_tran_data = '0;
        if ((r_state == SEND) && (r_served < r_word_cnt)) begin
            w_tran_data = r_rd_q;
            if (r_served == (r_word_cnt - 16'd1)) begin
                case (r_len_lsb)
                    2'd1:    w_tran_data = {24'h0, r_rd_q[7:0]};
                    2'd2:    w_tran_data = {16'h0, r_rd_q[15:0]};
                    2'd3:    w_tran_data = {8'h0, r_rd_q[23:0]};
                    default: w_tran_data = r_rd_q;
                endcase
            end
        end
    end

    assign wr_full_o    = r_ram_full || w_q_full;
    assign wr_err_o     = r_wr_err;
    assign tran_start_o = (r_state == START);
    assign tran_len_o   = r_tran_len;
    assign tran_data_o  = w_tran_data;

endmodule
